// File: rtl/drive_envelope_sequencer_pkg.sv
// drive_envelope_sequencer_pkg: default widths and FSM state type for the envelope sequencer
package drive_envelope_sequencer_pkg;
    localparam int DEF_PHASE_WIDTH     = 10;
    localparam int DEF_AMP_WIDTH       = 8;
    localparam int DEF_ACC_WIDTH       = 22;
    localparam int DEF_ENVE_NUM_ENTRY  = 256;
    localparam int DEF_ENVE_ADDR_WIDTH = 8;
    typedef enum logic {IDLE, PLAY} state_t;
endpackage

// File: rtl/drive_envelope_sequencer_if.sv
// drive_envelope_sequencer_if: config, envelope write, pulse request and sample output bundle
interface drive_envelope_sequencer_if
    import drive_envelope_sequencer_pkg::*;
#(
    parameter int PHASE_WIDTH     = DEF_PHASE_WIDTH,
    parameter int AMP_WIDTH       = DEF_AMP_WIDTH,
    parameter int ACC_WIDTH       = DEF_ACC_WIDTH,
    parameter int ENVE_ADDR_WIDTH = DEF_ENVE_ADDR_WIDTH
);
    logic                             ftw_wr_en;
    logic [ACC_WIDTH-1:0]             ftw_wr_data;
    logic                             enve_wr_en;
    logic [ENVE_ADDR_WIDTH-1:0]       enve_wr_addr;
    logic [PHASE_WIDTH+AMP_WIDTH-1:0] enve_wr_data;
    logic                             pulse_start;
    logic [ENVE_ADDR_WIDTH-1:0]       pulse_start_addr;
    logic [ENVE_ADDR_WIDTH:0]         pulse_length;
    logic                             pulse_busy;
    logic                             pulse_done;
    logic [PHASE_WIDTH-1:0]           nco_phase;
    logic [PHASE_WIDTH-1:0]           enve_memory_phase;
    logic [AMP_WIDTH-1:0]             enve_memory_amp;
    logic                             valid_out;
    modport master (
        output ftw_wr_en, ftw_wr_data, enve_wr_en, enve_wr_addr, enve_wr_data,
               pulse_start, pulse_start_addr, pulse_length,
        input  pulse_busy, pulse_done, nco_phase, enve_memory_phase, enve_memory_amp, valid_out
    );
    modport slave (
        input  ftw_wr_en, ftw_wr_data, enve_wr_en, enve_wr_addr, enve_wr_data,
               pulse_start, pulse_start_addr, pulse_length,
        output pulse_busy, pulse_done, nco_phase, enve_memory_phase, enve_memory_amp, valid_out
    );
endinterface

// File: rtl/drive_envelope_sequencer_enve_memory_param.sv
// enve_memory_param: 1W/1R synchronous-read envelope RAM, old data returned on write/read collision
module enve_memory_param #(
    parameter int DATA_WIDTH = 18,
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_data;
    always_ff @(posedge clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
    end
    assign o_rd_data = r_rd_data;
endmodule

// File: rtl/drive_envelope_sequencer.sv
// drive_envelope_sequencer: free-running NCO plus envelope pulse player feeding the polar modulator
module drive_envelope_sequencer
    import drive_envelope_sequencer_pkg::*;
#(
    parameter int PHASE_WIDTH     = DEF_PHASE_WIDTH,
    parameter int AMP_WIDTH       = DEF_AMP_WIDTH,
    parameter int ACC_WIDTH       = DEF_ACC_WIDTH,
    parameter int ENVE_NUM_ENTRY  = DEF_ENVE_NUM_ENTRY,
    parameter int ENVE_ADDR_WIDTH = DEF_ENVE_ADDR_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    drive_envelope_sequencer_if.slave  io_bus
);
    localparam int SAMPLE_WIDTH = PHASE_WIDTH + AMP_WIDTH;

    state_t                     r_state, w_state_nx;
    logic [ACC_WIDTH-1:0]       r_acc, r_ftw;
    logic [PHASE_WIDTH-1:0]     r_nco_phase;
    logic [ENVE_ADDR_WIDTH-1:0] r_addr, w_addr_nx;
    logic [ENVE_ADDR_WIDTH:0]   r_cnt, w_cnt_nx;
    logic                       r_valid, r_done;
    logic                       w_play, w_last;
    logic [SAMPLE_WIDTH-1:0]    w_rd_data;

    assign w_play = (r_state == PLAY);
    assign w_last = w_play && (r_cnt == (ENVE_ADDR_WIDTH+1)'(1));

    // nco_phase lags acc by one register so it lines up with the synchronous memory read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc       <= '0;
            r_ftw       <= '0;
            r_nco_phase <= '0;
        end else begin
            r_acc       <= r_acc + r_ftw;
            r_nco_phase <= r_acc[ACC_WIDTH-1 -: PHASE_WIDTH];
            if (io_bus.ftw_wr_en) r_ftw <= io_bus.ftw_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_addr  <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_addr  <= w_addr_nx;
            r_cnt   <= w_cnt_nx;
            r_valid <= w_play;
            r_done  <= w_last;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_addr_nx  = r_addr;
        w_cnt_nx   = r_cnt;
        if (w_play) begin
            w_addr_nx  = r_addr + 1'b1;
            w_cnt_nx   = r_cnt - 1'b1;
            w_state_nx = w_last ? IDLE : PLAY;
        end else if (io_bus.pulse_start && io_bus.pulse_length != '0) begin
            w_state_nx = PLAY;
            w_addr_nx  = io_bus.pulse_start_addr;
            w_cnt_nx   = io_bus.pulse_length;
        end
    end

    enve_memory_param #(
        .DATA_WIDTH (SAMPLE_WIDTH),
        .DEPTH      (ENVE_NUM_ENTRY),
        .ADDR_WIDTH (ENVE_ADDR_WIDTH)
    ) u_enve_memory (
        .clk       (clk),
        .i_wr_en   (io_bus.enve_wr_en),
        .i_wr_addr (io_bus.enve_wr_addr),
        .i_wr_data (io_bus.enve_wr_data),
        .i_rd_en   (w_play),
        .i_rd_addr (r_addr),
        .o_rd_data (w_rd_data)
    );

    assign io_bus.pulse_busy        = w_play;
    assign io_bus.pulse_done        = r_done;
    assign io_bus.nco_phase         = r_nco_phase;
    assign io_bus.valid_out         = r_valid;
    assign io_bus.enve_memory_phase = r_valid ? w_rd_data[SAMPLE_WIDTH-1 -: PHASE_WIDTH] : '0;
    assign io_bus.enve_memory_amp   = r_valid ? w_rd_data[AMP_WIDTH-1:0] : '0;
endmodule

// File: tb/tb_drive_envelope_sequencer.sv
// tb_drive_envelope_sequencer: random and directed pulses scored against a queue-based reference model
module tb_drive_envelope_sequencer;
    typedef struct packed {
        logic [9:0] ph;
        logic [7:0] amp;
        logic       done;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    drive_envelope_sequencer_if bus ();
    drive_envelope_sequencer dut (.clk(clk), .rst_n(rst_n), .io_bus(bus));

    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];
    logic [17:0] mem_m [256];
    int          m_rem = 0;
    logic [7:0]  m_addr = '0;
    logic [21:0] acc_m = '0;
    logic [21:0] ftw_m = '0;
    logic        exp_valid = 1'b0;
    logic        exp_busy = 1'b0;
    logic [9:0]  exp_nco = '0;
    logic [9:0]  prev_nco = '0;
    int          wrap_seen = 0;

    function automatic void chk(string name, int act, int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endfunction

    // Reference model: reads take the memory as it stood before this edge's write
    task automatic step();
        bit         idle;
        bit         n_valid;
        logic [9:0] n_nco;
        exp_t       e;
        n_valid = 1'b0;
        n_nco = '0;
        if (rst_n) begin
            idle = (m_rem == 0);
            if (!idle) begin
                e.ph   = mem_m[m_addr][17:8];
                e.amp  = mem_m[m_addr][7:0];
                e.done = (m_rem == 1);
                sb.push_back(e);
                m_addr++;
                m_rem--;
                n_valid = 1'b1;
            end
            if (bus.enve_wr_en) mem_m[bus.enve_wr_addr] = bus.enve_wr_data;
            if (idle && bus.pulse_start && bus.pulse_length != 0) begin
                m_rem  = int'(bus.pulse_length);
                m_addr = bus.pulse_start_addr;
            end
            n_nco = acc_m[21:12];
            acc_m = acc_m + ftw_m;
            if (bus.ftw_wr_en) ftw_m = bus.ftw_wr_data;
        end
        @(posedge clk);
        #1;
        if (rst_n) begin
            exp_valid = n_valid;
            exp_busy  = (m_rem != 0);
            exp_nco   = n_nco;
        end
        bus.pulse_start = 1'b0;
        bus.enve_wr_en  = 1'b0;
        bus.ftw_wr_en   = 1'b0;
    endtask

    task automatic start(input logic [7:0] addr, input logic [8:0] len);
        bus.pulse_start      = 1'b1;
        bus.pulse_start_addr = addr;
        bus.pulse_length     = len;
        step();
    endtask

    task automatic wr(input logic [7:0] addr, input logic [17:0] data);
        bus.enve_wr_en   = 1'b1;
        bus.enve_wr_addr = addr;
        bus.enve_wr_data = data;
        step();
    endtask

    task automatic wr_ftw(input logic [21:0] data);
        bus.ftw_wr_en   = 1'b1;
        bus.ftw_wr_data = data;
        step();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && m_rem != 0; i++) step();
    endtask

    always @(negedge clk) begin
        exp_t e;
        chk("valid", int'(bus.valid_out), int'(exp_valid));
        chk("busy", int'(bus.pulse_busy), int'(exp_busy));
        chk("nco_phase", int'(bus.nco_phase), int'(exp_nco));
        if (bus.valid_out) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_sample", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("sample_phase", int'(bus.enve_memory_phase), int'(e.ph));
                chk("sample_amp", int'(bus.enve_memory_amp), int'(e.amp));
                chk("sample_done", int'(bus.pulse_done), int'(e.done));
            end
        end else begin
            chk("idle_done", int'(bus.pulse_done), 0);
            chk("idle_phase", int'(bus.enve_memory_phase), 0);
            chk("idle_amp", int'(bus.enve_memory_amp), 0);
        end
        if (prev_nco == 10'h3FF && bus.nco_phase == 10'h000) wrap_seen = 1;
        prev_nco = bus.nco_phase;
    end

    initial begin
        logic [7:0] k8;
        bus.ftw_wr_en = 1'b0;
        bus.ftw_wr_data = '0;
        bus.enve_wr_en = 1'b0;
        bus.enve_wr_addr = '0;
        bus.enve_wr_data = '0;
        bus.pulse_start = 1'b0;
        bus.pulse_start_addr = '0;
        bus.pulse_length = '0;
        for (int i = 0; i < 256; i++) mem_m[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 256; k++) begin
            k8 = 8'(k);
            wr(k8, {2'b00, k8, k8});
        end
        wr_ftw(22'h1000);
        repeat (1100) step();
        chk("nco_wrap_3ff_to_0", wrap_seen, 1);
        start(8'd4, 9'd3);
        wait_idle();
        step();
        start(8'd254, 9'd4);
        wait_idle();
        step();
        start(8'd10, 9'd3);
        start(8'd50, 9'd5);
        wait_idle();
        step();
        start(8'd7, 9'd0);
        repeat (4) step();
        start(8'd0, 9'd256);
        wait_idle();
        start(8'd100, 9'd2);
        wait_idle();
        start(8'd20, 9'd2);
        wait_idle();
        step();
        start(8'd3, 9'd5);
        step();
        step();
        wr(8'd5, {10'h2AA, 8'h55});
        wait_idle();
        start(8'd5, 9'd1);
        wait_idle();
        step();
        start(8'd0, 9'd20);
        repeat (5) step();
        chk("pre_reset_valid", int'(bus.valid_out), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", int'(bus.pulse_busy), 0);
        chk("rst_done", int'(bus.pulse_done), 0);
        chk("rst_valid", int'(bus.valid_out), 0);
        chk("rst_nco", int'(bus.nco_phase), 0);
        chk("rst_phase", int'(bus.enve_memory_phase), 0);
        chk("rst_amp", int'(bus.enve_memory_amp), 0);
        m_rem = 0;
        acc_m = '0;
        ftw_m = '0;
        sb.delete();
        exp_valid = 1'b0;
        exp_busy = 1'b0;
        exp_nco = '0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        start(8'd30, 9'd6);
        wait_idle();
        wr_ftw(22'($urandom));
        for (int i = 0; i < 300; i++) begin
            int r;
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 2) == 0) begin
                bus.enve_wr_en   = 1'b1;
                bus.enve_wr_addr = 8'($urandom);
                bus.enve_wr_data = 18'($urandom);
            end
            if (r == 3) begin
                bus.ftw_wr_en   = 1'b1;
                bus.ftw_wr_data = 22'($urandom);
            end
            if (r >= 4 && r <= 6) begin
                bus.pulse_start      = 1'b1;
                bus.pulse_start_addr = 8'($urandom);
                bus.pulse_length     = (r == 6) ? 9'($urandom_range(0, 256)) : 9'($urandom_range(0, 8));
            end
            step();
        end
        wait_idle();
        repeat (3) step();
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
